// File: rtl/rgb_fade_scheduler_pkg.sv
// Shared types, state encoding and the rainbow colour table for the fade scheduler.
// Also holds the duty-scaling helper used by the top level.
package rgb_fade_pkg;

    localparam int NUM_COLORS = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RISE = 3'd1,
        ST_HOLD = 3'd2,
        ST_FALL = 3'd3,
        ST_NEXT = 3'd4
    } fade_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Order: red, orange, yellow, green, blue, indigo, purple
    localparam logic [7:0] COLOR_R [NUM_COLORS] = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   8'd8,  8'd160};
    localparam logic [7:0] COLOR_G [NUM_COLORS] = '{8'd0,   8'd60,  8'd255, 8'd255, 8'd0,   8'd46, 8'd32};
    localparam logic [7:0] COLOR_B [NUM_COLORS] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd84, 8'd240};

    function automatic rgb_t color_target(input logic [2:0] idx);
        rgb_t rgb;
        if (idx < 3'(NUM_COLORS)) begin
            rgb.r = COLOR_R[idx];
            rgb.g = COLOR_G[idx];
            rgb.b = COLOR_B[idx];
        end else begin
            rgb = '0;
        end
        return rgb;
    endfunction

    // Rounds up so a full target at full level reaches 255 and a zero level gives 0.
    function automatic logic [7:0] scale_duty(input logic [7:0] target, input logic [7:0] level);
        logic [15:0] prod;
        prod = 16'(target) * 16'(level) + 16'd255;
        return prod[15:8];
    endfunction

endpackage

// File: rtl/rgb_fade_scheduler_if.sv
// Board-side bundle for the fade scheduler: run controls in, duties, PWM and status out.
interface rgb_fade_scheduler_if;
    logic       i_en;
    logic       i_skip;
    logic [7:0] o_r_duty;
    logic [7:0] o_g_duty;
    logic [7:0] o_b_duty;
    logic       o_pwm_r;
    logic       o_pwm_g;
    logic       o_pwm_b;
    logic [2:0] o_color_idx;
    logic       o_cycle_done;

    modport master (
        output i_en, i_skip,
        input  o_r_duty, o_g_duty, o_b_duty,
        input  o_pwm_r, o_pwm_g, o_pwm_b,
        input  o_color_idx, o_cycle_done
    );

    modport slave (
        input  i_en, i_skip,
        output o_r_duty, o_g_duty, o_b_duty,
        output o_pwm_r, o_pwm_g, o_pwm_b,
        output o_color_idx, o_cycle_done
    );
endinterface

// File: rtl/rgb_fade_scheduler_pwm_channel.sv
// One PWM output: compares the shared 0..254 counter against an 8-bit duty.
// Duty 0 never drives high, duty 255 always does because the counter stops at 254.
module pwm_channel (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_duty,
    input  logic [7:0] i_pwm_cnt,
    output logic       o_pwm
);

    logic r_pwm;

    // Registered compare so the pin never sees comparator glitches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (i_pwm_cnt < i_duty);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_fade_scheduler.sv
// Table-driven rainbow fader: ramps each colour up, holds, ramps down, advances.
// Level and colour are scaled into registered duties that feed three PWM channels.
module rgb_fade_scheduler
    import rgb_fade_pkg::*;
#(
    parameter int CLK_DIV    = 625000,
    parameter int HOLD_TICKS = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rgb_fade_scheduler_if.slave  bus
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [2:0]        LAST_COLOR = 3'(NUM_COLORS - 1);
    localparam logic [7:0]        PWM_LAST   = 8'd254;

    logic              w_en;
    logic              w_skip;
    logic              w_tick;
    logic [CNT_W-1:0]  r_cnt;
    fade_state_e       r_state;
    fade_state_e       w_state_nxt;
    logic [7:0]        r_level;
    logic [7:0]        w_level_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [2:0]        r_color_idx;
    logic [2:0]        w_color_nxt;
    logic              w_wrap;
    logic              r_cycle_done;
    rgb_t              w_target;
    logic [7:0]        r_duty_r;
    logic [7:0]        r_duty_g;
    logic [7:0]        r_duty_b;
    logic [7:0]        r_pwm_cnt;
    logic              w_pwm_r;
    logic              w_pwm_g;
    logic              w_pwm_b;

    assign w_en   = bus.i_en;
    assign w_skip = bus.i_skip & bus.i_en;
    assign w_tick = w_en & (r_cnt == CNT_LAST);

    // Fade-tick prescaler, frozen while paused.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Sequencer state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: skip beats a coincident tick; everything freezes while paused.
    always_comb begin
        w_state_nxt = r_state;
        if (w_en) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_RISE;
                ST_RISE: begin
                    if (w_skip) begin
                        w_state_nxt = ST_FALL;
                    end else if (w_tick && (r_level == 8'd254)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_RISE;
                    end
                end
                ST_HOLD: begin
                    if (w_skip) begin
                        w_state_nxt = ST_FALL;
                    end else if (w_tick && (r_hold_cnt == HOLD_LAST)) begin
                        w_state_nxt = ST_FALL;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_FALL: begin
                    if (w_tick && (r_level <= 8'd1)) begin
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_state_nxt = ST_FALL;
                    end
                end
                ST_NEXT: w_state_nxt = ST_RISE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Datapath updates per state; a level of 0 in FALL (skip right at rise start) ends the fall.
    always_comb begin
        w_level_nxt = r_level;
        w_hold_nxt  = r_hold_cnt;
        w_color_nxt = r_color_idx;
        w_wrap      = 1'b0;
        if (w_en) begin
            case (r_state)
                ST_IDLE: begin
                    w_level_nxt = 8'd0;
                    w_hold_nxt  = '0;
                end
                ST_RISE: begin
                    if (!w_skip && w_tick) begin
                        w_level_nxt = r_level + 8'd1;
                        w_hold_nxt  = '0;
                    end else begin
                        w_level_nxt = r_level;
                    end
                end
                ST_HOLD: begin
                    if (!w_skip && w_tick && (r_hold_cnt != HOLD_LAST)) begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end else begin
                        w_hold_nxt = r_hold_cnt;
                    end
                end
                ST_FALL: begin
                    if (w_tick && (r_level <= 8'd1)) begin
                        w_level_nxt = 8'd0;
                    end else if (w_tick) begin
                        w_level_nxt = r_level - 8'd1;
                    end else begin
                        w_level_nxt = r_level;
                    end
                end
                ST_NEXT: begin
                    w_wrap = (r_color_idx == LAST_COLOR);
                    if (r_color_idx >= LAST_COLOR) begin
                        w_color_nxt = 3'd0;
                    end else begin
                        w_color_nxt = r_color_idx + 3'd1;
                    end
                end
                default: begin
                    w_level_nxt = 8'd0;
                    w_hold_nxt  = '0;
                    w_color_nxt = 3'd0;
                end
            endcase
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Level, hold counter, colour index and wrap pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level      <= 8'd0;
            r_hold_cnt   <= '0;
            r_color_idx  <= 3'd0;
            r_cycle_done <= 1'b0;
        end else begin
            r_level      <= w_level_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_color_idx  <= w_color_nxt;
            r_cycle_done <= w_wrap;
        end
    end

    assign w_target = color_target(r_color_idx);

    // Duties follow the level/colour one clock later, and keep running while paused.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_duty_r <= 8'd0;
            r_duty_g <= 8'd0;
            r_duty_b <= 8'd0;
        end else begin
            r_duty_r <= scale_duty(w_target.r, r_level);
            r_duty_g <= scale_duty(w_target.g, r_level);
            r_duty_b <= scale_duty(w_target.b, r_level);
        end
    end

    // Shared free-running PWM period counter, independent of the run enable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pwm_cnt <= 8'd0;
        end else if (r_pwm_cnt == PWM_LAST) begin
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    pwm_channel u_pwm_r (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_duty    (r_duty_r),
        .i_pwm_cnt (r_pwm_cnt),
        .o_pwm     (w_pwm_r)
    );

    pwm_channel u_pwm_g (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_duty    (r_duty_g),
        .i_pwm_cnt (r_pwm_cnt),
        .o_pwm     (w_pwm_g)
    );

    pwm_channel u_pwm_b (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_duty    (r_duty_b),
        .i_pwm_cnt (r_pwm_cnt),
        .o_pwm     (w_pwm_b)
    );

    assign bus.o_r_duty     = r_duty_r;
    assign bus.o_g_duty     = r_duty_g;
    assign bus.o_b_duty     = r_duty_b;
    assign bus.o_pwm_r      = w_pwm_r;
    assign bus.o_pwm_g      = w_pwm_g;
    assign bus.o_pwm_b      = w_pwm_b;
    assign bus.o_color_idx  = r_color_idx;
    assign bus.o_cycle_done = r_cycle_done;

endmodule

// File: tb/tb_rgb_fade_scheduler.sv
// Scoreboard bench: a phase/tick-count model predicts every cycle's outputs,
// a monitor pops and compares them; directed pauses measure PWM high time.
module tb_rgb_fade_scheduler;

    localparam int CLK_DIV    = 4;
    localparam int HOLD_TICKS = 2;
    localparam int MAX_ITER   = 40000;
    localparam int P_IDLE = 0, P_RISE = 1, P_HOLD = 2, P_FALL = 3, P_NEXT = 4;

    localparam int TGT_R [7] = '{255, 255, 255, 0,   0,   8,  160};
    localparam int TGT_G [7] = '{0,   60,  255, 255, 0,   46, 32};
    localparam int TGT_B [7] = '{0,   0,   0,   0,   255, 84, 240};

    typedef struct packed {
        logic [2:0] color;
        logic       cd;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] pwm;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rgb_fade_scheduler_if bus ();

    rgb_fade_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks  = 0;
    int    errors  = 0;
    int    cd_seen = 0;
    snap_t exp_q [$];

    // Reference model: phase, level and counts of elapsed ticks/cycles.
    int m_phase, m_level, m_hold, m_color, m_en_cycles, m_cycles;
    int m_wraps = 0;
    int m_duty [3];
    bit m_pwm  [3];
    bit m_cd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_level = 0; m_hold = 0; m_color = 0;
        m_en_cycles = 0; m_cycles = 0; m_cd = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_duty[c] = 0;
            m_pwm[c]  = 1'b0;
        end
    endtask

    task automatic model_step(input bit en, input bit skip);
        bit tick;
        int cnt;
        int tg [3];
        tick  = en && ((m_en_cycles % CLK_DIV) == (CLK_DIV - 1));
        cnt   = m_cycles % 255;
        tg[0] = TGT_R[m_color];
        tg[1] = TGT_G[m_color];
        tg[2] = TGT_B[m_color];
        for (int c = 0; c < 3; c++) begin
            m_pwm[c]  = (cnt < m_duty[c]);
            m_duty[c] = (tg[c] * m_level + 255) / 256;
        end
        m_cd = 1'b0;
        if (en) begin
            case (m_phase)
                P_IDLE: begin m_phase = P_RISE; m_level = 0; end
                P_RISE: begin
                    if (skip) m_phase = P_FALL;
                    else if (tick) begin
                        m_level++;
                        if (m_level == 255) begin m_phase = P_HOLD; m_hold = 0; end
                    end
                end
                P_HOLD: begin
                    if (skip) m_phase = P_FALL;
                    else if (tick) begin
                        m_hold++;
                        if (m_hold == HOLD_TICKS) m_phase = P_FALL;
                    end
                end
                P_FALL: begin
                    if (tick) begin
                        m_level = (m_level > 0) ? m_level - 1 : 0;
                        if (m_level == 0) m_phase = P_NEXT;
                    end
                end
                P_NEXT: begin
                    m_cd = (m_color == 6);
                    if (m_cd) m_wraps++;
                    m_color = (m_color + 1) % 7;
                    m_phase = P_RISE;
                end
                default: ;
            endcase
            m_en_cycles++;
        end
        m_cycles++;
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.color = 3'(m_color);
        s.cd    = m_cd;
        s.r     = 8'(m_duty[0]);
        s.g     = 8'(m_duty[1]);
        s.b     = 8'(m_duty[2]);
        s.pwm   = {m_pwm[0], m_pwm[1], m_pwm[2]};
        return s;
    endfunction

    task automatic cycle(input bit en, input bit skip);
        @(negedge clk);
        rst        = 1'b0;
        bus.i_en   = en;
        bus.i_skip = skip;
        model_step(en, skip);
        exp_q.push_back(snap());
    endtask

    task automatic reset_cycle(input bit check_now);
        @(negedge clk);
        rst        = 1'b1;
        bus.i_en   = 1'b0;
        bus.i_skip = 1'b0;
        if (check_now) begin
            #1;
            check("reset_async",
                  32'({bus.o_color_idx, bus.o_cycle_done, bus.o_r_duty, bus.o_g_duty, bus.o_b_duty,
                       bus.o_pwm_r, bus.o_pwm_g, bus.o_pwm_b}), 32'd0);
        end
        model_reset();
        exp_q.push_back(snap());
    endtask

    // Pause long enough that a 255-clock window sees exactly 'duty' high clocks per channel.
    task automatic pause_count(input string tag, input int want_r, input int want_g, input int want_b);
        int hr, hg, hb;
        hr = 0; hg = 0; hb = 0;
        for (int i = 0; i < 270; i++) begin
            cycle(1'b0, 1'b0);
            if (i >= 10 && i < 265) begin
                hr += int'(bus.o_pwm_r);
                hg += int'(bus.o_pwm_g);
                hb += int'(bus.o_pwm_b);
            end
        end
        check({tag, "_r_high"}, 32'(hr), 32'(want_r));
        check({tag, "_g_high"}, 32'(hg), 32'(want_g));
        check({tag, "_b_high"}, 32'(hb), 32'(want_b));
    endtask

    always @(posedge clk) begin : monitor
        snap_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (bus.o_cycle_done) cd_seen++;
            check("color_idx", 32'(bus.o_color_idx), 32'(e.color));
            check("cycle_done", 32'(bus.o_cycle_done), 32'(e.cd));
            check("duty_rgb", 32'({bus.o_r_duty, bus.o_g_duty, bus.o_b_duty}), 32'({e.r, e.g, e.b}));
            check("pwm_rgb", 32'({bus.o_pwm_r, bus.o_pwm_g, bus.o_pwm_b}), 32'(e.pwm));
        end
    end

    initial begin : stimulus
        bit en, sk, tick_next, finished;
        bit did_reset, done_r64, done_rhold, done_or, done_skip, done_fskip, done_ind, done_pur;
        finished = 0; did_reset = 0; done_r64 = 0; done_rhold = 0; done_or = 0;
        done_skip = 0; done_fskip = 0; done_ind = 0; done_pur = 0;
        bus.i_en   = 1'b0;
        bus.i_skip = 1'b0;
        model_reset();
        repeat (3) reset_cycle(1'b0);

        for (int n = 0; n < MAX_ITER && !finished; n++) begin
            tick_next = ((m_en_cycles % CLK_DIV) == (CLK_DIV - 1));
            if (!did_reset && m_color == 0 && m_phase == P_RISE && m_level == 40) begin
                did_reset = 1'b1;
                reset_cycle(1'b1);
                reset_cycle(1'b0);
            end else if (did_reset && !done_r64 && m_color == 0 && m_phase == P_RISE && m_level == 64) begin
                done_r64 = 1'b1;
                pause_count("red64", 64, 0, 0);
            end else if (!done_rhold && m_color == 0 && m_phase == P_HOLD) begin
                done_rhold = 1'b1;
                pause_count("redhold", 255, 0, 0);
            end else if (!done_or && m_color == 1 && m_phase == P_RISE && m_level == 128) begin
                done_or = 1'b1;
                repeat (3) cycle(1'b0, 1'b0);
                check("orange128", 32'({bus.o_r_duty, bus.o_g_duty, bus.o_b_duty}),
                      32'({8'd128, 8'd30, 8'd0}));
            end else if (!done_skip && m_color == 2 && m_phase == P_RISE && m_level == 100 && tick_next) begin
                done_skip = 1'b1;
                cycle(1'b1, 1'b1);
            end else if (done_skip && !done_fskip && m_color == 2 && m_phase == P_FALL && m_level == 50) begin
                done_fskip = 1'b1;
                cycle(1'b1, 1'b1);
            end else if (!done_ind && m_color == 5 && m_phase == P_HOLD) begin
                done_ind = 1'b1;
                pause_count("indigo", 8, 46, 84);
            end else if (!done_pur && m_color == 6 && m_phase == P_HOLD) begin
                done_pur = 1'b1;
                pause_count("purple", 160, 32, 240);
                check("purple255", 32'({bus.o_r_duty, bus.o_g_duty, bus.o_b_duty}),
                      32'({8'd160, 8'd32, 8'd240}));
            end else if (m_wraps >= 1 && m_color == 1 && m_level >= 8) begin
                finished = 1'b1;
            end else begin
                en = ($urandom_range(0, 31) != 0);
                sk = (m_color == 3 || m_color == 4) && ($urandom_range(0, 511) == 0);
                cycle(en, sk);
            end
        end

        @(posedge clk);
        #2;
        check("run_complete", 32'(finished), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("cycle_done_pulses", 32'(cd_seen), 32'(m_wraps));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_fade_scheduler.md
# rgb_fade_scheduler

- Sequences the RGB LED datapath through a fixed seven-colour rainbow.
- For each colour it ramps a brightness level up, holds it, ramps it down, then advances to the next colour.
- Scales each colour's target RGB by the level to produce 8-bit duty values and drives three PWM outputs from those duties.
- Sits between board controls (run enable, skip button) and the LED pins. It replaces ad-hoc per-colour ramp logic with one table-driven scheduler.

## Interface
- CLK_DIV, 625000: clock cycles per fade tick; must be ≥ 2.
- HOLD_TICKS, 32: fade ticks spent at full level per colour; must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  run enable; low pauses the sequence.
- skip  in  1  single-cycle pulse (already synchronised/debounced upstream); forces the current colour into its fall phase.
- R_duty, G_duty, B_duty  out  8 each  current duty values, registered.
- pwm_r, pwm_g, pwm_b  out  1 each  PWM outputs, registered.
- color_idx  out  3  current colour index, 0..6.
- cycle_done  out  1  one-cycle pulse when color_idx wraps from 6 to 0.

## Operation
**Reset.** All of the following are 0: state (IDLE), level, hold_cnt, prescaler, pwm_cnt, color_idx, all duties, all pwm outputs, cycle_done.

**Prescaler.** `cnt` counts 0..CLK_DIV-1 and wraps. `tick` is high for the one cycle where cnt == CLK_DIV-1. The prescaler runs only while en=1; when en=0 it holds its value.

**State machine** (states IDLE, RISE, HOLD, FALL, NEXT):
- IDLE: when en=1, go to RISE on the next clock with level=0.
- RISE: on tick, level+1. When level==254 on a tick, level becomes 255 and the state goes to HOLD with hold_cnt=0.
- HOLD: on tick, hold_cnt+1. When hold_cnt==HOLD_TICKS-1 on a tick, go to FALL.
- FALL: on tick, level-1. When level==1 on a tick, level becomes 0 and the state goes to NEXT.
- NEXT: lasts exactly one clock, with no tick required.
  - color_idx = (color_idx==6) ? 0 : color_idx+1.
  - cycle_done=1 on the wrap only.
  - Then go to RISE.

**Skip.** With skip=1 and en=1 in RISE or HOLD, the next state is FALL and level is unchanged that cycle. Skip takes priority over a simultaneous tick. Skip is ignored in IDLE, FALL and NEXT, and whenever en=0.

**Pause.** en=0 freezes state, level, hold_cnt and color_idx. Duties and PWM keep running at their frozen values.

**Colour table** (R,G,B):
- 0 red (255,0,0)
- 1 orange (255,60,0)
- 2 yellow (255,255,0)
- 3 green (0,255,0)
- 4 blue (0,0,255)
- 5 indigo (8,46,84)
- 6 purple (160,32,240)

**Scaling.** X_duty = (target_X*level + 255) >> 8, with a 16-bit product (max 65280, no overflow). This gives duty 0 when level=0 or target=0, and duty 255 when target=255 and level=255.

**PWM.**
- pwm_cnt is free-running 0..254 (period 255 clocks). It is unaffected by en.
- pwm_X is registered from (pwm_cnt < X_duty): duty 0 is always low, duty 255 is always high.

## Timing
- A level or color_idx update appears on the duty outputs one clock later.
- A duty change appears on pwm_X one clock after that; the new duty governs every compare from then on.
- cycle_done is asserted in the same cycle that color_idx shows 0 after the wrap.
- Ticks per colour, without skip: 255 rise + HOLD_TICKS + 255 fall, plus 1 clock for NEXT.
- rst mid-fade returns every register to its reset value immediately (asynchronous). Restart proceeds from IDLE with color_idx 0.

## Structure
- Package `rgb_fade_pkg` holds:
  - state encoding constants;
  - the seven-entry colour table as R/G/B constant arrays;
  - NUM_COLORS=7.
- Sub-module `pwm_channel` (8-bit duty in, shared pwm_cnt in, registered pwm out) is instantiated three times.
- Prescaler, FSM and scaling stay in the top module.

## Test plan
(Benches use CLK_DIV=4, HOLD_TICKS=2.)
1. **Reset.** Assert rst mid-RISE → all outputs 0 in the same cycle; after release with en=1, state RISE and color_idx 0.
2. **Red ramp.** en=1 from reset → after 255 ticks R_duty=255, G_duty=B_duty=0; 2 ticks of HOLD; after 255 more ticks R_duty=0; color_idx becomes 1.
3. **Orange scaling.** Colour 1 at level 128 → R_duty=128, G_duty=30, B_duty=0. Purple at level 255 → 160/32/240.
4. **Skip.** Pulse skip at level 100 in RISE of colour 2, coincident with a tick → level stays 100, state FALL; after 100 ticks color_idx=3. Skip during FALL → no effect.
5. **Pause and wrap.**
   - en=0 for 50 clocks mid-HOLD → level, hold_cnt and color_idx unchanged, PWM still toggling.
   - Full run through colour 6 → color_idx 0 with cycle_done high for exactly one clock.
6. **PWM duty.** Duty 0 → pwm low for 255 clocks. Duty 255 → high for 255 clocks. Duty 64 → exactly 64 high clocks per 255-clock period.
